board_game_ctrl: RTL and testbench
==================================

Name: board_game_ctrl

Overview:
- Game-play stage directly downstream of the board generator.
- Captures the 12-bit board the generator presents while in CHOSE_BOARD.
- Runs the tile-swap puzzle: the player moves a cursor and swaps adjacent tiles until the board reads 0,1,2,3.
- Owns and publishes game_status, which the generator consumes to select its own output.

Parameters:
- CNT_W, 8, width of the move counter; the counter saturates at 2^CNT_W-1.
- CURSOR_WRAP, 0, 0 = cursor saturates at the ends; 1 = cursor wraps 2->0 on right and 0->2 on left.
- MOVE_LIMIT, 20, maximum number of swaps allowed; used only when BOARD_MOVE_LIMIT_EN is defined.

Ports:
- clk_d  in  1  block clock.
- rst  in  1  reset, active-low, synchronous, sampled on posedge clk_d.
- board_in  in  12  board from the generator. Tile at position p is bits[11-3p -: 3]; position 0 is leftmost.
- confirm  in  1  single-cycle pulse: accept the presented board, or leave WINNED.
- btn_left  in  1  single-cycle pulse: move cursor left.
- btn_right  in  1  single-cycle pulse: move cursor right.
- btn_swap  in  1  single-cycle pulse: swap tiles at positions cursor and cursor+1.
- btn_restart  in  1  single-cycle pulse: replay the captured board from the start.
- btn_abort  in  1  single-cycle pulse: return to board selection.
- game_status  out  2  00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED.
- board  out  12  current play board, same packing as board_in.
- cursor  out  2  left index of the selected pair, range 0..2.
- move_cnt  out  CNT_W  swaps made in the current attempt.
- win  out  1  one-cycle pulse on entry to WINNED.
- lose  out  1  one-cycle pulse on move-limit failure; constant 0 unless the macro is defined.

Behaviour:
- All registers update on posedge clk_d only.
- Reset (rst=0) values: game_status=CHOSE_BOARD, board=12'b000_001_010_011, init_board=same, cursor=0, move_cnt=0, win=0, lose=0.
- The button inputs are already debounced and single-cycle upstream.
- At most one action is taken per cycle. Priority: btn_abort > btn_restart > confirm > btn_swap > btn_right > btn_left. Lower-priority inputs in the same cycle are dropped, not queued.
- CHOSE_BOARD:
  - Buttons other than confirm are ignored.
  - On confirm: board<=board_in, init_board<=board_in, cursor<=0, move_cnt<=0, next state GAME_INITIAL.
  - Capture happens on the confirm edge, while the generator still presents the selected board. The generator forces 0123 from the next cycle onward.
- GAME_INITIAL lasts exactly 1 cycle:
  - If board equals 000_001_010_011, next state is WINNED and win pulses. A pre-solved board is an immediate win with move_cnt=0.
  - Otherwise next state is GAMING.
  - Inputs are ignored, except btn_abort, which goes to CHOSE_BOARD.
- GAMING:
  - btn_left: cursor-1. At 0 it holds 0 if CURSOR_WRAP=0, or goes to 2 if CURSOR_WRAP=1.
  - btn_right: cursor+1. At 2 it holds 2 if CURSOR_WRAP=0, or goes to 0 if CURSOR_WRAP=1.
  - btn_swap: exchange the 3-bit fields at cursor and cursor+1. move_cnt increments, saturating at all-ones. Cursor is unchanged.
  - Win check is on the registered board. The cycle after a swap makes the board 000_001_010_011, state goes to WINNED and win=1 for that one cycle. Swap latency to win is 1 clock.
  - btn_restart: board<=init_board, cursor<=0, move_cnt<=0, next state GAME_INITIAL.
  - btn_abort: next state CHOSE_BOARD; board resets to 000_001_010_011, cursor=0, move_cnt=0.
- WINNED:
  - board and move_cnt are frozen; left, right and swap are ignored.
  - confirm or btn_abort goes to CHOSE_BOARD.
  - btn_restart replays init_board via GAME_INITIAL.
- Encoding 11 is a legal state. No unreachable encodings exist.
- Reset asserted mid-game takes priority over everything and restores the reset values on that edge.

Optional Feature:
- Macro name: BOARD_MOVE_LIMIT_EN.
- Defined:
  - In GAMING, if a swap makes move_cnt reach MOVE_LIMIT, the next cycle checks for a solve first.
  - If the board is solved, the win path is taken.
  - Otherwise lose pulses for 1 cycle and the state goes to GAME_INITIAL with board<=init_board, cursor<=0, move_cnt<=0. This is an automatic restart.
- Undefined: lose is tied to 0; move_cnt only saturates.

Test Plan:
- Reset, then board_in=001_000_010_011 and confirm -> game_status 10 for 1 cycle, then 01; board=1023; cursor=0.
- From 1023: btn_swap -> board=0123, move_cnt=1; next cycle game_status=11 and win=1 for exactly 1 cycle.
- Board 0132, cursor=0: btn_right x3 -> cursor=2 (saturated); btn_swap -> win, move_cnt=1. Repeat with CURSOR_WRAP=1: the third btn_right gives cursor=0.
- Confirm with board_in=0123 -> GAME_INITIAL, then WINNED with move_cnt=0. Then confirm -> CHOSE_BOARD.
- In GAMING after 3 swaps, btn_restart and btn_swap in the same cycle -> board=init_board, move_cnt=0, game_status=10, and the swap is dropped. Also drive rst=0 mid-game -> every output takes its reset value on that edge.
- With BOARD_MOVE_LIMIT_EN and MOVE_LIMIT=4: start from 3210 and make 4 non-solving swaps -> lose=1 for 1 cycle, board=3210, move_cnt=0, game_status=10.

Source files
------------

// File: rtl/board_game_ctrl_if.sv
// Game-play bus between the board generator / player buttons and board_game_ctrl.
// The master side drives the board and button pulses; the slave side publishes play state.
interface board_game_ctrl_if #(
  parameter int CNT_W = 8
);
  // Handshake: there is no valid/ready pair. Every button is a single-cycle pulse that the
  // controller always samples; a pulse that loses on priority that cycle is dropped, never held.
  logic [11:0]      board_in;
  logic             confirm;
  logic             btn_left;
  logic             btn_right;
  logic             btn_swap;
  logic             btn_restart;
  logic             btn_abort;
  logic [1:0]       game_status;
  logic [11:0]      board;
  logic [1:0]       cursor;
  logic [CNT_W-1:0] move_cnt;
  logic             win;
  logic             lose;

  modport master (
    output board_in, confirm, btn_left, btn_right, btn_swap, btn_restart, btn_abort,
    input  game_status, board, cursor, move_cnt, win, lose
  );

  modport slave (
    input  board_in, confirm, btn_left, btn_right, btn_swap, btn_restart, btn_abort,
    output game_status, board, cursor, move_cnt, win, lose
  );
endinterface

// File: rtl/board_game_ctrl.sv
// Tile-swap puzzle controller: captures a board, lets the player swap adjacent tiles until 0,1,2,3.
// Optional move limit with automatic restart is enabled by defining BOARD_MOVE_LIMIT_EN.
module board_game_ctrl #(
  parameter int CNT_W       = 8,
  parameter bit CURSOR_WRAP = 1'b0,
  parameter int MOVE_LIMIT  = 20
) (
  input logic               clk_d,
  input logic               rst,
  board_game_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {
    S_CHOSE_BOARD  = 2'b00,
    S_GAMING       = 2'b01,
    S_GAME_INITIAL = 2'b10,
    S_WINNED       = 2'b11
  } state_t;

  localparam logic [11:0]      SOLVED  = 12'b000_001_010_011;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [11:0]      r_board;
  logic [11:0]      r_init_board;
  logic [1:0]       r_cursor;
  logic [CNT_W-1:0] r_move_cnt;
  logic             r_win;

  logic             w_solved;
  logic [11:0]      w_swapped;
  logic [1:0]       w_cursor_left;
  logic [1:0]       w_cursor_right;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_solved       = (r_board == SOLVED);
  assign w_cursor_right = (r_cursor >= 2'd2) ? (CURSOR_WRAP ? 2'd0 : 2'd2) : r_cursor + 2'd1;
  assign w_cursor_left  = (r_cursor == 2'd0) ? (CURSOR_WRAP ? 2'd2 : 2'd0) : r_cursor - 2'd1;
  assign w_cnt_inc      = (r_move_cnt == CNT_MAX) ? r_move_cnt : r_move_cnt + CNT_W'(1);

  // Position 0 is the most significant field; the pair is (cursor, cursor+1).
  always_comb begin
    w_swapped = r_board;
    case (r_cursor)
      2'd0:    w_swapped = {r_board[8:6], r_board[11:9], r_board[5:0]};
      2'd1:    w_swapped = {r_board[11:9], r_board[5:3], r_board[8:6], r_board[2:0]};
      2'd2:    w_swapped = {r_board[11:6], r_board[2:0], r_board[5:3]};
      default: w_swapped = r_board;
    endcase
  end

`ifdef BOARD_MOVE_LIMIT_EN
  logic r_lose;
  logic w_limit_hit;
  // The count can only sit at the limit in GAMING on the cycle right after the limiting swap.
  assign w_limit_hit = (r_move_cnt == CNT_W'(MOVE_LIMIT));
`endif

  always_ff @(posedge clk_d) begin
    if (!rst) begin
      r_state      <= S_CHOSE_BOARD;
      r_board      <= SOLVED;
      r_init_board <= SOLVED;
      r_cursor     <= 2'd0;
      r_move_cnt   <= '0;
      r_win        <= 1'b0;
`ifdef BOARD_MOVE_LIMIT_EN
      r_lose       <= 1'b0;
`endif
    end else begin
      r_win <= 1'b0;
`ifdef BOARD_MOVE_LIMIT_EN
      r_lose <= 1'b0;
`endif
      case (r_state)
        S_CHOSE_BOARD: begin
          if (bus.confirm) begin
            r_board      <= bus.board_in;
            r_init_board <= bus.board_in;
            r_cursor     <= 2'd0;
            r_move_cnt   <= '0;
            r_state      <= S_GAME_INITIAL;
          end
        end
        S_GAME_INITIAL: begin
          if (bus.btn_abort) begin
            r_state    <= S_CHOSE_BOARD;
            r_board    <= SOLVED;
            r_cursor   <= 2'd0;
            r_move_cnt <= '0;
          end else if (w_solved) begin
            r_state <= S_WINNED;
            r_win   <= 1'b1;
          end else begin
            r_state <= S_GAMING;
          end
        end
        S_GAMING: begin
          if (bus.btn_abort) begin
            r_state    <= S_CHOSE_BOARD;
            r_board    <= SOLVED;
            r_cursor   <= 2'd0;
            r_move_cnt <= '0;
          end else if (bus.btn_restart) begin
            r_state    <= S_GAME_INITIAL;
            r_board    <= r_init_board;
            r_cursor   <= 2'd0;
            r_move_cnt <= '0;
          end else if (w_solved) begin
            r_state <= S_WINNED;
            r_win   <= 1'b1;
`ifdef BOARD_MOVE_LIMIT_EN
          end else if (w_limit_hit) begin
            r_lose     <= 1'b1;
            r_state    <= S_GAME_INITIAL;
            r_board    <= r_init_board;
            r_cursor   <= 2'd0;
            r_move_cnt <= '0;
`endif
          end else if (!bus.confirm) begin
            // confirm has no effect here but still outranks the play buttons.
            if (bus.btn_swap) begin
              r_board    <= w_swapped;
              r_move_cnt <= w_cnt_inc;
            end else if (bus.btn_right) begin
              r_cursor <= w_cursor_right;
            end else if (bus.btn_left) begin
              r_cursor <= w_cursor_left;
            end
          end
        end
        S_WINNED: begin
          if (bus.btn_abort) begin
            r_state    <= S_CHOSE_BOARD;
            r_board    <= SOLVED;
            r_cursor   <= 2'd0;
            r_move_cnt <= '0;
          end else if (bus.btn_restart) begin
            r_state    <= S_GAME_INITIAL;
            r_board    <= r_init_board;
            r_cursor   <= 2'd0;
            r_move_cnt <= '0;
          end else if (bus.confirm) begin
            r_state    <= S_CHOSE_BOARD;
            r_board    <= SOLVED;
            r_cursor   <= 2'd0;
            r_move_cnt <= '0;
          end
        end
        default: r_state <= S_CHOSE_BOARD;
      endcase
    end
  end

  assign bus.game_status = r_state;
  assign bus.board       = r_board;
  assign bus.cursor      = r_cursor;
  assign bus.move_cnt    = r_move_cnt;
  assign bus.win         = r_win;
`ifdef BOARD_MOVE_LIMIT_EN
  assign bus.lose        = r_lose;
`else
  assign bus.lose        = 1'b0;
`endif
endmodule

// File: tb/tb_board_game_ctrl.sv
// Bench for board_game_ctrl: directed test-plan steps followed by random play, checked against
// a tile-array model of the puzzle rules.
module tb_board_game_ctrl;
  localparam int CNT_W = 8;
  localparam bit WRAP  = 1'b0;
  localparam int LIMIT = 20;
  localparam int EXP_W = 2 + 12 + 2 + CNT_W + 2;
  localparam logic [5:0] B_ABORT = 6'b100000, B_RESTART = 6'b010000, B_CONFIRM = 6'b001000,
                         B_SWAP = 6'b000100, B_RIGHT = 6'b000010, B_LEFT = 6'b000001, B_NONE = 6'b0;

  // ---------------- clock / reset ----------------
  logic clk_d = 1'b0;
  logic rst;
  always #5 clk_d = ~clk_d;

  board_game_ctrl_if #(.CNT_W(CNT_W)) bus ();

  board_game_ctrl #(.CNT_W(CNT_W), .CURSOR_WRAP(WRAP), .MOVE_LIMIT(LIMIT)) dut (
    .clk_d (clk_d),
    .rst   (rst),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  int m_state;  // 0 choose, 1 gaming, 2 initial, 3 won
  int m_tiles[4];
  int m_init[4];
  int m_cur;
  int m_cnt;
  int m_win;
  int m_lose;
  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  function automatic logic [11:0] mk(input int a, input int b, input int c, input int d);
    return {3'(a), 3'(b), 3'(c), 3'(d)};
  endfunction

  function automatic bit m_solved();
    return m_tiles[0] == 0 && m_tiles[1] == 1 && m_tiles[2] == 2 && m_tiles[3] == 3;
  endfunction

  function automatic void m_select();
    m_state = 0;
    m_tiles = '{0, 1, 2, 3};
    m_cur   = 0;
    m_cnt   = 0;
  endfunction

  function automatic void m_replay();
    m_state = 2;
    m_tiles = m_init;
    m_cur   = 0;
    m_cnt   = 0;
  endfunction

  function automatic void m_step();
    int tmp;
    logic [11:0] b;
    m_win  = 0;
    m_lose = 0;
    if (!rst) begin
      m_select();
      m_init = '{0, 1, 2, 3};
    end else begin
      case (m_state)
        0: if (bus.confirm) begin
          for (int p = 0; p < 4; p++) m_tiles[p] = int'((bus.board_in >> (9 - 3 * p)) & 12'd7);
          m_init = m_tiles;
          m_cur  = 0;
          m_cnt  = 0;
          m_state = 2;
        end
        2: begin
          if (bus.btn_abort) m_select();
          else if (m_solved()) begin m_state = 3; m_win = 1; end
          else m_state = 1;
        end
        1: begin
          if (bus.btn_abort) m_select();
          else if (bus.btn_restart) m_replay();
          else if (m_solved()) begin m_state = 3; m_win = 1; end
`ifdef BOARD_MOVE_LIMIT_EN
          else if (m_cnt == LIMIT) begin m_lose = 1; m_replay(); end
`endif
          else if (bus.confirm) begin end
          else if (bus.btn_swap) begin
            tmp = m_tiles[m_cur];
            m_tiles[m_cur] = m_tiles[m_cur + 1];
            m_tiles[m_cur + 1] = tmp;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
          end else if (bus.btn_right) begin
            if (m_cur < 2) m_cur++;
            else m_cur = WRAP ? 0 : 2;
          end else if (bus.btn_left) begin
            if (m_cur > 0) m_cur--;
            else m_cur = WRAP ? 2 : 0;
          end
        end
        default: begin
          if (bus.btn_abort) m_select();
          else if (bus.btn_restart) m_replay();
          else if (bus.confirm) m_select();
        end
      endcase
    end
    b = mk(m_tiles[0], m_tiles[1], m_tiles[2], m_tiles[3]);
    exp_q.push_back({2'(m_state), b, 2'(m_cur), CNT_W'(m_cnt), 1'(m_win), 1'(m_lose)});
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_f(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      check_f("game_status", 32'(bus.game_status), 32'(e[EXP_W-1 -: 2]));
      check_f("board",       32'(bus.board),       32'(e[EXP_W-3 -: 12]));
      check_f("cursor",      32'(bus.cursor),      32'(e[CNT_W+3 -: 2]));
      check_f("move_cnt",    32'(bus.move_cnt),    32'(e[CNT_W+1 -: CNT_W]));
      check_f("win",         32'(bus.win),         32'(e[1]));
      check_f("lose",        32'(bus.lose),        32'(e[0]));
    end
  endtask

  // ---------------- driver ----------------
  task automatic press(input logic [5:0] btns, input logic [11:0] bi);
    {bus.btn_abort, bus.btn_restart, bus.confirm, bus.btn_swap, bus.btn_right, bus.btn_left} = btns;
    bus.board_in = bi;
    @(posedge clk_d);
    m_step();
    @(negedge clk_d);
    check_outputs();
    {bus.btn_abort, bus.btn_restart, bus.confirm, bus.btn_swap, bus.btn_right, bus.btn_left} = B_NONE;
  endtask

  function automatic logic [11:0] rand_board();
    int a[4];
    int j;
    int t;
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 12'($urandom);
    a = '{0, 1, 2, 3};
    if (k < 6) begin
      for (int i = 3; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = a[i]; a[i] = a[j]; a[j] = t;
      end
    end else begin
      j = $urandom_range(0, 2);
      t = a[j]; a[j] = a[j + 1]; a[j + 1] = t;
    end
    return mk(a[0], a[1], a[2], a[3]);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] btns;
    int r;
    rst = 1'b0;
    bus.board_in = 12'd0;
    {bus.btn_abort, bus.btn_restart, bus.confirm, bus.btn_swap, bus.btn_right, bus.btn_left} = B_NONE;
    press(B_NONE, 12'd0);
    press(B_CONFIRM, mk(1, 0, 2, 3));
    check_f("reset_status", 32'(bus.game_status), 32'd0);
    check_f("reset_board", 32'(bus.board), 32'h053);
    rst = 1'b1;

    // Capture 1023, one swap solves it.
    press(B_CONFIRM, mk(1, 0, 2, 3));
    check_f("tp_initial", 32'(bus.game_status), 32'd2);
    press(B_NONE, 12'd0);
    check_f("tp_gaming", 32'(bus.game_status), 32'd1);
    check_f("tp_board1023", 32'(bus.board), 32'(mk(1, 0, 2, 3)));
    press(B_SWAP, 12'd0);
    check_f("tp_swap_cnt", 32'(bus.move_cnt), 32'd1);
    press(B_NONE, 12'd0);
    check_f("tp_win_pulse", 32'(bus.win), 32'd1);
    press(B_NONE, 12'd0);
    press(B_CONFIRM, 12'd0);

    // 0132: right three times, then swap.
    press(B_CONFIRM, mk(0, 1, 3, 2));
    press(B_NONE, 12'd0);
    press(B_RIGHT, 12'd0);
    press(B_RIGHT, 12'd0);
    press(B_RIGHT, 12'd0);
    check_f("tp_cursor_end", 32'(bus.cursor), WRAP ? 32'd0 : 32'd2);
    press(B_SWAP, 12'd0);
    press(B_NONE, 12'd0);
    press(B_ABORT, 12'd0);

    // Pre-solved board wins immediately with no moves.
    press(B_CONFIRM, mk(0, 1, 2, 3));
    press(B_NONE, 12'd0);
    check_f("tp_presolved", 32'(bus.game_status), 32'd3);
    press(B_CONFIRM, 12'd0);
    check_f("tp_back_to_choose", 32'(bus.game_status), 32'd0);

    // Three swaps, then restart+swap together; then a mid-game reset.
    press(B_CONFIRM, mk(3, 2, 1, 0));
    press(B_NONE, 12'd0);
    press(B_SWAP, 12'd0);
    press(B_RIGHT, 12'd0);
    press(B_SWAP, 12'd0);
    press(B_LEFT, 12'd0);
    press(B_SWAP, 12'd0);
    press(B_RESTART | B_SWAP, 12'd0);
    check_f("tp_restart_board", 32'(bus.board), 32'(mk(3, 2, 1, 0)));
    check_f("tp_restart_cnt", 32'(bus.move_cnt), 32'd0);
    press(B_NONE, 12'd0);
    press(B_SWAP, 12'd0);
    rst = 1'b0;
    press(B_SWAP, 12'd0);
    check_f("tp_midreset_board", 32'(bus.board), 32'h053);
    rst = 1'b1;

    // Non-solving swaps up to the move limit.
    press(B_CONFIRM, mk(3, 2, 1, 0));
    press(B_NONE, 12'd0);
    for (int i = 0; i < LIMIT; i++) press(B_SWAP, 12'd0);
    press(B_NONE, 12'd0);
`ifdef BOARD_MOVE_LIMIT_EN
    check_f("tp_lose", 32'(bus.lose), 32'd1);
`endif
    press(B_ABORT, 12'd0);

    // Random play.
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) btns = B_ABORT;
      else if (r < 4) btns = B_RESTART;
      else if (r < 12) btns = B_CONFIRM;
      else if (r < 45) btns = B_SWAP;
      else if (r < 65) btns = B_RIGHT;
      else if (r < 85) btns = B_LEFT;
      else btns = B_NONE;
      if ($urandom_range(0, 9) == 0) btns = btns | 6'($urandom_range(0, 63));
      rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      press(btns, rand_board());
    end
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
